// File: rtl/uart_boot_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_boot_loader_if : serial input, BSRAM write port and boot status.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface uart_boot_loader_if #(
  parameter int ADDR_W = 11
);
  logic              uart_rx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic              boot_mode;
  logic              boot_done;
  logic              err;

  modport master (
    input  uart_rx,
    output mem_we, mem_addr, mem_din, boot_mode, boot_done, err
  );

  modport slave (
    output uart_rx,
    input  mem_we, mem_addr, mem_din, boot_mode, boot_done, err
  );
endinterface
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_boot_loader : loads a checksummed UART image into instruction BSRAM. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 234,
  parameter int ADDR_W       = 11,
  parameter int MAX_WORDS    = 255,
  parameter int TIMEOUT_CLKS = 2700000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  uart_boot_loader_if.master bus
);
  localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT + 1);
  localparam int                 c_tmo_w     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last  = c_tmo_w'(TIMEOUT_CLKS - 1);
  localparam logic [8:0]         c_max_words = 9'(MAX_WORDS);

  typedef enum logic [1:0] {RX_WAIT_START, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM} state_t;

  rx_state_t          rx_state_q;
  logic [1:0]         sync_q;
  logic               rx_prev_q;
  logic [c_cnt_w-1:0] bit_cnt_q;
  logic [2:0]         bit_idx_q;
  logic [7:0]         shift_q;
  logic [7:0]         rx_byte_q;
  logic               rx_valid_q;
  logic               rx_ferr_q;

  state_t             state_q;
  logic [c_tmo_w-1:0] tmo_q;
  logic [7:0]         len_q;
  logic [7:0]         wcnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         hi_q;
  logic [7:0]         sum_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [15:0]        mem_din_q;
  logic               boot_mode_q;
  logic               boot_done_q;
  logic               err_q;

  // Receiver: start edge on the synchronised line, mid-bit sampling thereafter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_WAIT_START;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], bus.uart_rx};
      rx_prev_q  <= sync_q[1];
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        RX_WAIT_START: begin
          if (rx_prev_q && !sync_q[1]) begin
            rx_state_q <= RX_START;
            bit_cnt_q  <= '0;
          end
        end
        RX_START: begin
          if (bit_cnt_q == c_half_last) begin
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            rx_state_q <= sync_q[1] ? RX_WAIT_START : RX_DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt_q == c_bit_last) begin
            bit_cnt_q <= '0;
            shift_q   <= {sync_q[1], shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_cnt_q == c_bit_last) begin
            if (sync_q[1]) begin
              rx_valid_q <= 1'b1;
              rx_byte_q  <= shift_q;
            end else begin
              rx_ferr_q <= 1'b1;
            end
            rx_state_q <= RX_WAIT_START;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_WAIT_START;
      endcase
    end
  end

  // Frame parser and BSRAM writer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      len_q       <= '0;
      wcnt_q      <= '0;
      addr_q      <= '0;
      hi_q        <= '0;
      sum_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      boot_mode_q <= 1'b1;
      boot_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (state_q == S_IDLE || rx_valid_q) tmo_q <= '0;
      else if (state_q != S_WRITE)         tmo_q <= tmo_q + 1'b1;

      if (rx_ferr_q) begin
        err_q   <= 1'b1;
        state_q <= S_IDLE;
      end else if (state_q != S_IDLE && state_q != S_WRITE && !rx_valid_q &&
                   tmo_q == c_tmo_last) begin
        err_q   <= 1'b1;
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rx_valid_q && rx_byte_q == 8'hA5) begin
              err_q       <= 1'b0;
              boot_done_q <= 1'b0;
              boot_mode_q <= 1'b1;
              state_q     <= S_LEN;
            end
          end
          S_LEN: begin
            if (rx_valid_q) begin
              if (rx_byte_q == 8'd0 || {1'b0, rx_byte_q} > c_max_words) begin
                err_q   <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                len_q   <= rx_byte_q;
                wcnt_q  <= '0;
                addr_q  <= '0;
                sum_q   <= '0;
                state_q <= S_HI;
              end
            end
          end
          S_HI: begin
            if (rx_valid_q) begin
              hi_q    <= rx_byte_q;
              sum_q   <= sum_q + rx_byte_q;
              state_q <= S_LO;
            end
          end
          S_LO: begin
            if (rx_valid_q) begin
              mem_din_q  <= {hi_q, rx_byte_q};
              mem_addr_q <= addr_q;
              mem_we_q   <= 1'b1;
              sum_q      <= sum_q + rx_byte_q;
              state_q    <= S_WRITE;
            end
          end
          S_WRITE: begin
            addr_q  <= addr_q + 1'b1;
            wcnt_q  <= wcnt_q + 8'd1;
            state_q <= (wcnt_q + 8'd1 == len_q) ? S_CSUM : S_HI;
          end
          S_CSUM: begin
            if (rx_valid_q) begin
              if (rx_byte_q == sum_q) begin
                boot_done_q <= 1'b1;
                boot_mode_q <= 1'b0;
              end else begin
                err_q <= 1'b1;
              end
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.boot_mode = boot_mode_q;
  assign bus.boot_done = boot_done_q;
  assign bus.err       = err_q;
endmodule
`default_nettype wire
